// File: rtl/spi_cfg_pkg.sv
// Shared constants and types for the SPI configuration target feeding pwm_peripheral.
package spi_cfg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    localparam int FRAME_BITS = 16;

    // Bit counter saturates one past a full frame so overlong frames stay distinguishable.
    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_SAT  = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchroniser bringing one asynchronous pin into the clk domain.
module cdc_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 target holding the five PWM configuration registers.
//   state  | meaning
//   IDLE   | waiting for a fresh nCS falling edge
//   SHIFT  | shifting COPI on SCLK rising edges, counting bits
//   COMMIT | one cycle: apply the frame if it is a valid 16-bit write
module spi_peripheral
    import spi_cfg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       cfg_update
);

    logic sclk_s, copi_s, ncs_s;
    logic sclk_prev, ncs_prev;
    logic sclk_rise, ncs_rise, ncs_fall;
    logic [SYNC_STAGES:0] fill;
    logic armed;

    state_t state, state_nxt;
    logic [FRAME_BITS-1:0] shift_q, shift_nxt;
    logic [4:0] cnt_q, cnt_nxt;
    logic wr_en;

    cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
    );
    cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s)
    );
    cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s)
    );

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;

    // The ncs chain resets high, so a pin held low through reset would look like a
    // falling edge; only accept a falling edge once real pin data has shown nCS high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
            fill      <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
            armed     <= armed | (fill[SYNC_STAGES] & ncs_s);
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall && armed) begin
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_nxt = COMMIT;
                end else if (sclk_rise) begin
                    shift_nxt = {shift_q[FRAME_BITS-2:0], copi_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_nxt = cnt_q + 5'd1;
                    end
                end
            end
            COMMIT: begin
                wr_en     = (cnt_q == CNT_FULL) && shift_q[FRAME_BITS-1] &&
                            (shift_q[FRAME_BITS-2:8] <= MAX_ADDR);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            cfg_update      <= 1'b0;
        end else begin
            cfg_update <= wr_en;
            if (wr_en) begin
                case (shift_q[FRAME_BITS-2:8])
                    ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= shift_q[7:0];
                    ADDR_EN_OUT_15_8: en_reg_out_15_8 <= shift_q[7:0];
                    ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= shift_q[7:0];
                    ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= shift_q[7:0];
                    ADDR_PWM_DUTY:    pwm_duty_cycle  <= shift_q[7:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

Write-only SPI mode-0 target that holds the PWM block's five configuration registers. It sits between the dedicated input pins (SCLK, COPI, nCS) and `pwm_peripheral`. It synchronises the SPI pins into `clk`, assembles 16-bit frames and commits a single register write when nCS rises. There is no read-back path; the block drives no CIPO.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops per synchroniser chain, minimum 2.
- `MAX_ADDR`, default 7'h04: highest valid register address.

Ports:
- `clk` in 1: system clock. The block uses one clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sclk` in 1: SPI clock, asynchronous to `clk`. Driven from ui_in[0].
- `copi` in 1: SPI data in, MSB first. Driven from ui_in[1].
- `ncs` in 1: SPI chip select, active-low. Driven from ui_in[2].
- `en_reg_out_7_0` out 8: output-enable register, address 0x00.
- `en_reg_out_15_8` out 8: output-enable register, address 0x01.
- `en_reg_pwm_7_0` out 8: PWM-mode enable register, address 0x02.
- `en_reg_pwm_15_8` out 8: PWM-mode enable register, address 0x03.
- `pwm_duty_cycle` out 8: duty-cycle register, address 0x04.
- `cfg_update` out 1: one-cycle pulse on every committed write.

## Operation
**Frame format:** bit15 is R/W (1 = write), bits 14:8 are the address, bits 7:0 are the data. The controller sends it MSB first and the block samples it on SCLK rising edges.

**Synchronisers:** each of `sclk`, `copi` and `ncs` passes through a `SYNC_STAGES` chain. Reset values are sclk 0, copi 0, ncs 1. One extra flop per line feeds the edge detectors. `copi` is sampled from the same stage as the detected `sclk` edge.

**States:**
- IDLE. Waits for a falling edge on synchronised `ncs`, then clears the shift register and the bit counter and moves to SHIFT.
- SHIFT. On each synchronised SCLK rising edge it shifts in COPI and increments the bit counter. The 5-bit counter saturates at 17, which marks the frame as overlong. A rising edge on `ncs` moves the FSM to COMMIT.
- COMMIT. Lasts one cycle. A write happens only if the counter is exactly 16, R/W is 1 and the address is ≤ `MAX_ADDR`. In that case the addressed register takes the data byte and `cfg_update` pulses. In every other case nothing changes. The FSM then returns to IDLE.

**Discarded frames:** read frames, addresses 0x05–0x7F, short frames and long frames are all dropped silently.

**Edge collisions:**
- An SCLK edge detected in the same cycle as the nCS rising edge is ignored.
- SCLK edges seen while in IDLE are ignored.

**Reset:**
- All registers, the shift register, the counter and `cfg_update` reset to 0.
- The FSM resets to IDLE.
- A reset in the middle of a frame abandons that frame. If nCS is still low when reset is released, the block waits for a fresh nCS falling edge, so the tail of the abandoned frame is never committed.

Registers hold their values indefinitely between writes.

## Timing
- A pin transition is detected SYNC_STAGES+1 `clk` edges later, which is 3 edges at the default setting.
- Register outputs and `cfg_update` change on the 4th `clk` rising edge after the nCS pin rises (default settings), counting the COMMIT cycle.
- `cfg_update` is high for exactly one cycle per committed write.
- Host requirements, all measured in `clk` periods:
  - SCLK high time and low time each ≥ SYNC_STAGES+1 (3 at default).
  - COPI stable from before each SCLK rising edge until 1 period after it.
  - nCS rising edge ≥ SYNC_STAGES+1 after the last SCLK rising edge.
  - nCS high time ≥ SYNC_STAGES+2.
- Back-to-back frames are supported as long as the nCS high time is met.

## Structure
- Package `spi_cfg_pkg` holds:
  - the address constants `ADDR_EN_OUT_7_0` (0x00) through `ADDR_PWM_DUTY` (0x04);
  - `FRAME_BITS` = 16;
  - the FSM state enum {IDLE, SHIFT, COMMIT}.
- One sub-module, `cdc_sync`: a parameterised multi-flop synchroniser with a reset-value parameter, instantiated three times.

## Test plan
- Write frame 0x80F0 (address 0x00, data 0xF0) → `en_reg_out_7_0` = 0xF0, one `cfg_update` pulse, all other registers stay 0x00.
- Write frames to addresses 0x01–0x04 with data 0xAA, 0x55, 0x0F, 0x80 → each register holds its value; `pwm_duty_cycle` = 0x80.
- Read frame 0x00FF, and write frame 0xB012 (address 0x30) → no register change, no `cfg_update`.
- A 12-bit frame and a 17-bit frame, each with write bit set, address 0x00, data 0x33 → both discarded; `en_reg_out_7_0` keeps its prior value.
- `rst_n` pulsed low after 8 bits of frame 0x8255, with nCS still low and the remaining 8 bits then sent → all registers read 0x00 and nothing is committed. A following full frame 0x8255 → `en_reg_pwm_7_0` = 0x55.
- Minimum timing: SCLK with 3-cycle high and low phases, nCS 3 cycles after the last SCLK edge, 0x8142 → `en_reg_out_15_8` = 0x42, updated on the 4th `clk` edge after nCS rises.
